// File: rtl/axi_grid_ch_fifo.sv
// rtl/axi_grid_ch_fifo.sv - elastic circular-buffer FIFO for one grid channel, upstream of the MNI.
// Optional zero-cycle bypass when empty: define AXI_GRID_CH_FIFO_BYPASS_EN.

package axi_default_param_pkg;
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } grid_aw_chan_t;
endpackage

module axi_grid_ch_fifo #(
  parameter type         data_t = axi_default_param_pkg::grid_aw_chan_t,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned CW    = $clog2(DEPTH + 1),
  localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk_i,
  input  logic          arst_i,
  input  logic          flush_i,
  input  data_t         data_i,
  input  logic          valid_i,
  output logic          ready_o,
  output data_t         data_o,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  data_t         mem_q [DEPTH];
  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop, bypass;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  // No ready_i term here: a pop cannot make room for a same-cycle push.
  assign ready_o = !full_o && !flush_i;

`ifdef AXI_GRID_CH_FIFO_BYPASS_EN
  assign bypass  = empty_o && !flush_i && valid_i && ready_i;
  assign valid_o = !flush_i && (empty_o ? valid_i : 1'b1);
  assign data_o  = empty_o ? data_i : mem_q[rp_q];
`else
  assign bypass  = 1'b0;
  assign valid_o = !flush_i && !empty_o;
  assign data_o  = mem_q[rp_q];
`endif

  assign push = valid_i && ready_o && !bypass;
  assign pop  = valid_o && ready_i && !bypass;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (flush_i) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      // Explicit wrap so non-power-of-two depths work.
      if (push) wp_d = (wp_q == PW'(DEPTH - 1)) ? '0 : wp_q + PW'(1);
      if (pop)  rp_d = (rp_q == PW'(DEPTH - 1)) ? '0 : rp_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !flush_i) mem_q[wp_q] <= data_i;
  end

endmodule

// File: doc/axi_grid_ch_fifo.md
# axi_grid_ch_fifo

Type-parameterised elastic FIFO for one grid channel (AW, W, B, AR or R). It sits directly upstream of the manager network interface, between the grid router output port and the MNI channel input, so the MNI sees a steady valid/ready stream. One instance per channel absorbs router backpressure bursts and decouples timing between router and NI.

## Interface

Parameters:
- `data_t`, default `axi_default_param_pkg::grid_aw_chan_t`: payload type carried, stored opaquely.
- `DEPTH`, default 4: number of entries; legal range 2..256, any integer (not restricted to powers of two).

Ports (`CW = $clog2(DEPTH+1)`):
- `clk_i`, input, 1: clock; all state updates on the rising edge.
- `arst_i`, input, 1: asynchronous reset, active-high.
- `flush_i`, input, 1: synchronous clear of all entries.
- `data_i`, input, `$bits(data_t)`: upstream payload from the router.
- `valid_i`, input, 1: upstream valid.
- `ready_o`, output, 1: upstream ready; equals `!full_o && !flush_i`.
- `data_o`, output, `$bits(data_t)`: downstream payload to the MNI.
- `valid_o`, output, 1: downstream valid.
- `ready_i`, input, 1: downstream ready from the MNI.
- `count_o`, output, CW: number of stored entries, range 0..DEPTH.
- `full_o`, output, 1: `count_o == DEPTH`.
- `empty_o`, output, 1: `count_o == 0`.

## Operation

- Storage is a circular buffer of DEPTH `data_t` entries.
- Write pointer `wp` and read pointer `rp` each range over 0..DEPTH-1. Each wraps from DEPTH-1 to 0 by explicit compare, not by modulo-2^n.
- Push occurs when `valid_i && ready_o` and the bypass path is not taken. The entry is written at `wp`, then `wp` advances.
- Pop occurs when `valid_o && ready_i` and the bypass path is not taken. `rp` advances.
- Count update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged, both pointers advance
  - neither: unchanged
- `data_o` is the entry at `rp` while the FIFO is not empty.
- `data_o` is don't-care while `valid_o` is 0.
- Flush:
  - When `flush_i` is high at a clock edge, `wp`, `rp` and `count` go to 0.
  - Any concurrent push or pop is discarded.
  - `valid_o` is forced to 0 during that cycle.
- Full: `ready_o` = 0. A push cannot be accepted in the same cycle as a pop that frees the slot, because there is no combinational ready_i-to-ready_o path.
- Empty (no bypass): `valid_o` = 0.
- Ordering: strict FIFO. No reordering and no filtering of payload content.

## Timing

- Reset values (async, while `arst_i` is high):
  - `count_o` = 0, `empty_o` = 1, `full_o` = 0
  - `valid_o` = 0
  - `ready_o` = 1 (when `flush_i` = 0)
  - internal pointers = 0
- Storage array contents are not reset.
- Reset mid-operation discards all stored entries immediately; no partial transfer completes.
- Latency without bypass: a push accepted at edge N makes `valid_o` = 1 after edge N, in the same cycle `count_o` becomes 1.
- Throughput: one push and one pop per cycle sustained. With DEPTH ≥ 2 there are no bubbles while the FIFO holds between 1 and DEPTH-1 entries.
- `ready_o` depends only on registered state and `flush_i`. `valid_o` depends only on registered state, except on the bypass path.
- `valid_o` is never deasserted without a pop, flush or reset, as AXI requires of a stable source.

## Configuration

Macro: `AXI_GRID_CH_FIFO_BYPASS_EN`.
- Defined:
  - When `empty_o` = 1 and `flush_i` = 0: `valid_o = valid_i` and `data_o = data_i` combinationally.
  - If `ready_i` is also 1, the beat passes through in zero cycles and nothing is written.
  - If `ready_i` = 0, the beat is pushed normally.
- Not defined:
  - No combinational path from input to output.
  - Minimum latency is 1 cycle, as described under Timing.

## Test plan

All scenarios use DEPTH = 4.
- **Reset:** assert `arst_i` mid-stream with 3 entries held → `count_o` = 0, `empty_o` = 1, `valid_o` = 0 immediately. After release, `ready_o` = 1.
- **Fill/drain:** push 0xA1..0xA5 with `ready_i` = 0 → 4 accepted, `full_o` = 1, `ready_o` = 0 on the 5th. Then set `ready_i` = 1 → outputs A1, A2, A3, A4 in order, then `empty_o` = 1.
- **Wrap-around:** 10 rounds of push 3 / pop 3 → the pointers wrap past index 3 and all 30 values come out in order.
- **Simultaneous push/pop at count 2:** 20 cycles with `valid_i` = `ready_i` = 1 → `count_o` stays 2 and one beat is output per cycle.
- **Flush with concurrent push and pop at count 3:** → next cycle `count_o` = 0, and neither the pushed value nor a popped value is observed.
- **Bypass (macro defined, empty, `ready_i` = 1):** push 0x55 → `valid_o` = 1 with `data_o` = 0x55 in the same cycle, and `count_o` stays 0. Without the macro → 0x55 appears one cycle later.
